// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding Wishbone classic master fed by a command/response handshake
// Ports:
//   wb_clk_i, wb_rst_ni                 clock, asynchronous active-low reset
//   cmd_valid/ready/we/sel/adr/dat      command request channel (accepted only in IDLE)
//   rsp_valid/ready/dat/timeout         response channel (held until handshake)
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o, wbm_ack_i, wbm_dat_i   Wishbone classic master
//   busy                                high whenever a transfer or response is pending
// Optional feature: define WB_HOST_MASTER_TIMEOUT_EN to abort ack-less transfers after
// TIMEOUT_CYCLES bus cycles; otherwise BUS waits for ack forever and rsp_timeout is 0.
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic        abort;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = BUS;
                cyc_d   = 1'b1;
                we_d    = cmd_we;
                sel_d   = cmd_sel;
                adr_d   = cmd_adr;
                // reads never drive write data, so dat_o stays 0 around a read
                dat_d   = cmd_we ? cmd_dat : 32'h0;
            end
            // ack has priority over a coincident timeout
            BUS: if (wbm_ack_i || abort) begin
                state_d = RESP;
                cyc_d   = 1'b0;
                rdat_d  = (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    // counter holds (BUS cycle index - 1), so the terminal count hits on the TIMEOUT_CYCLES-th cycle
    localparam logic [15:0] TERM = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    assign abort = cnt_q >= TERM;
    assign cnt_d = (state_q != BUS) ? 16'h0 : (&cnt_q) ? cnt_q : cnt_q + 16'h1;
    assign to_d  = (state_q == BUS) ? (abort && !wbm_ack_i) : to_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= 16'h0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign rsp_timeout = to_q;
`else
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // gated by reset so the command channel reads not-ready while held in reset
    assign cmd_ready = (state_q == IDLE) && wb_rst_ni;
    assign rsp_valid = state_q == RESP;
    assign rsp_dat   = rdat_q;
    assign busy      = state_q != IDLE;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
endmodule
